read_return_mux: RTL and testbench

READ_RETURN_MUX -- requirements
Module: read_return_mux

---
 rtl/read_mux_pkg.sv | 23 ++
 rtl/rx_bit_counter.sv | 33 +++
 rtl/read_return_mux.sv | 133 +++++++++++++
 tb/tb_read_return_mux.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/read_mux_pkg.sv
// Shared types and helpers for the read-return mux.
// READ_MUX_PARITY_EN adds the PAR state used for the trailing parity bit.
package read_mux_pkg;

    // Width needed to index n items (never less than one bit).
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

`ifdef READ_MUX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/rx_bit_counter.sv
// Frame bit counter: cleared at frame start, counts sampled bits while enabled.
// tc flags the sample that completes the data portion of the frame.
module rx_bit_counter
    import read_mux_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = width_of(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);

    logic [CNT_W-1:0] count_q;

    // The FSM leaves DATA on tc, so the count never runs past DATA_BITS.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q == LAST);

endmodule

// File: rtl/read_return_mux.sv
// Routes either the arbiter line or one selected slave's serial read frame to the master.
// Build with READ_MUX_PARITY_EN to add the even-parity bit check after the data bits.
//
// state | meaning
// IDLE  | master_rx follows arbiter_data, waiting for rd_start
// DATA  | forwarding DATA_BITS data bits from the selected slave
// PAR   | forwarding and checking the parity bit (READ_MUX_PARITY_EN only)
module read_return_mux
    import read_mux_pkg::*;
#(
    parameter  int NUM_SLAVES = 3,
    parameter  int DATA_BITS  = 8,
    localparam int SEL_W      = width_of(NUM_SLAVES)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rd_start,
    input  logic                  rd_abort,
    input  logic [SEL_W-1:0]      slave_sel,
    input  logic [NUM_SLAVES-1:0] slave_rx,
    input  logic                  arbiter_data,
    output logic                  master_rx,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic                  sel_err,
    output logic                  parity_err
);

    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(NUM_SLAVES);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q;
    logic             sel_ok, accept, sel_bad, done_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic             rx_bit;

    assign sel_ok  = ({1'b0, slave_sel} < SEL_LIMIT);
    assign rx_bit  = slave_rx[sel_q];
    assign rd_busy = (state_q != IDLE);

    rx_bit_counter #(.DATA_BITS(DATA_BITS)) u_bit_counter (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        accept  = 1'b0;
        sel_bad = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // rd_abort has no meaning here, so rd_start always wins.
                if (rd_start) begin
                    if (sel_ok) begin
                        accept  = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = DATA;
                    end else begin
                        sel_bad = 1'b1;
                    end
                end
            end
            DATA: begin
                cnt_en = 1'b1;
                if (rd_abort) begin
                    state_d = IDLE;
                end else if (cnt_tc) begin
`ifdef READ_MUX_PARITY_EN
                    state_d = PAR;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef READ_MUX_PARITY_EN
            PAR: begin
                state_d = IDLE;
                done_d  = !rd_abort;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            master_rx <= 1'b0;
            rd_done   <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            master_rx <= (state_q == IDLE) ? arbiter_data : rx_bit;
            rd_done   <= done_d;
            sel_err   <= sel_bad;
            if (accept) begin
                sel_q <= slave_sel;
            end
        end
    end

`ifdef READ_MUX_PARITY_EN
    logic xor_q;
    logic perr_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            xor_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (accept) begin
                xor_q <= 1'b0;
            end else if (state_q == DATA) begin
                xor_q <= xor_q ^ rx_bit;
            end
            perr_q <= done_d && (rx_bit != xor_q);
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_read_return_mux.sv
// Scoreboard bench for read_return_mux: the driver queues hand-computed outputs per cycle,
// the monitor compares them after each rising edge. Parity cases need READ_MUX_PARITY_EN.
module tb_read_return_mux;

`ifdef READ_MUX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rd_start = 1'b0;
    logic       rd_abort = 1'b0;
    logic [1:0] slave_sel = '0;
    logic [2:0] slave_rx = '0;
    logic       arbiter_data = 1'b0;
    logic       master_rx, rd_busy, rd_done, sel_err, parity_err;

    // {master_rx, rd_busy, rd_done, sel_err, parity_err} after the edge
    typedef struct {
        logic [4:0] v;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    read_return_mux dut (
        .clk          (clk),
        .rstn         (rstn),
        .rd_start     (rd_start),
        .rd_abort     (rd_abort),
        .slave_sel    (slave_sel),
        .slave_rx     (slave_rx),
        .arbiter_data (arbiter_data),
        .master_rx    (master_rx),
        .rd_busy      (rd_busy),
        .rd_done      (rd_done),
        .sel_err      (sel_err),
        .parity_err   (parity_err)
    );

    task automatic cyc(input logic rn, input logic st, input logic ab, input logic [1:0] sel,
                       input logic [2:0] srx, input logic arb, input logic [4:0] exp_v,
                       input string tag);
        exp_t e;
        @(negedge clk);
        rstn = rn;
        rd_start = st;
        rd_abort = ab;
        slave_sel = sel;
        slave_rx = srx;
        arbiter_data = arb;
        e.v = exp_v;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Full frame, MSB first; unselected slaves and the arbiter carry the inverse bit.
    task automatic run_frame(input logic [1:0] sel, input logic [7:0] data, input logic pbit,
                             input logic perr, input logic arb, input logic ab);
        logic [2:0] srx;
        logic       last;
        cyc(1'b1, 1'b1, ab, sel, 3'b000, arb, {arb, 1'b1, 3'b000}, "frame_start");
        for (int i = 7; i >= 0; i--) begin
            srx = {3{~data[i]}};
            srx[sel] = data[i];
            last = (i == 0) && !PAR_EN;
            cyc(1'b1, 1'b0, 1'b0, sel, srx, ~data[i], {data[i], ~last, last, 2'b00}, "frame_bit");
        end
`ifdef READ_MUX_PARITY_EN
        srx = {3{~pbit}};
        srx[sel] = pbit;
        cyc(1'b1, 1'b0, 1'b0, sel, srx, ~pbit, {pbit, 1'b0, 1'b1, 1'b0, perr}, "frame_parity");
`else
        srx = {pbit, perr, 1'b0};
        srx = srx & 3'b000;
`endif
    endtask

    initial begin : monitor
        exp_t       e;
        logic [4:0] got;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = {master_rx, rd_busy, rd_done, sel_err, parity_err};
                total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL %s at %0t: master_rx,busy,done,sel_err,parity_err got %b want %b",
                             e.tag, $time, got, e.v);
                end
            end
        end
    end

    initial begin : driver
        // reset state, even with arbiter_data high
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 5'b00000, "reset");
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 5'b00000, "reset");
        // idle routing 1,0,1
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 5'b10000, "idle_route");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b111, 1'b0, 5'b00000, "idle_route");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 5'b10000, "idle_route");
        // basic read then back-to-back frame on another slave
        run_frame(2'd2, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(2'd1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b111, 1'b0, 5'b00000, "arb_resume");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 5'b10000, "arb_resume");
        // invalid select
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 3'b000, 1'b1, 5'b10010, "sel_err");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b111, 1'b0, 5'b00000, "sel_err_clear");
        // abort after 4 bits, with mid-frame starts ignored
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 5'b01000, "abort_start");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b001, 1'b0, 5'b11000, "abort_bit");
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 3'b110, 1'b1, 5'b01000, "busy_start_ignored");
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 3'b110, 1'b1, 5'b01000, "busy_bad_sel_ignored");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b001, 1'b0, 5'b11000, "abort_bit");
        cyc(1'b1, 1'b0, 1'b1, 2'd0, 3'b111, 1'b1, 5'b10000, "abort");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b111, 1'b0, 5'b00000, "abort_idle");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 5'b10000, "abort_idle");
        // reset mid-frame at bit 3, then a fresh frame with rd_abort alongside rd_start
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 1'b1, 5'b11000, "rst_start");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b001, 1'b0, 5'b11000, "rst_bit");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b001, 1'b0, 5'b11000, "rst_bit");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b001, 1'b0, 5'b11000, "rst_bit");
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 3'b001, 1'b1, 5'b00000, "mid_reset");
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b001, 1'b1, 5'b10000, "post_reset_idle");
        run_frame(2'd0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b111, 1'b0, 5'b00000, "post_frame_idle");
`ifdef READ_MUX_PARITY_EN
        // 8'hA5 has even weight: parity bit 1 is an error, 0 is clean
        run_frame(2'd2, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        run_frame(2'd2, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 5'b10000, "parity_idle");
`endif
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 5'b00000, "final_idle");
        repeat (3) @(posedge clk);
        #3;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
